// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the 2-of-3 majority vote used for mid-bit sampling.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A   = 7;
  localparam int SAMPLE_B   = 8;
  localparam int SAMPLE_C   = 9;
  localparam int CNT_LAST   = 15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial input; both flops reset
// to RESET_VAL so an idle-high line does not look like a start edge.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from the same edge and the chain really is two deep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver with a single-byte holding register,
// valid/ack handshake, framing-error and sticky overrun reporting.
module uart_rx_core #(
  parameter int         OVERSAMPLE = 16,
  parameter logic [7:0] RESET_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx_en,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] CNT_A    = CNT_W'(SAMPLE_A);
  localparam logic [CNT_W-1:0] CNT_B    = CNT_W'(SAMPLE_B);
  localparam logic [CNT_W-1:0] CNT_C    = CNT_W'(SAMPLE_C);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CNT_LAST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  uart_rx_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bi_q;
  logic [7:0]       sh_q;
  logic             samp_a_q;
  logic             samp_b_q;

  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;

  logic             rxs;
  logic             maj_d;
  logic             commit_d;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rxd),
    .q_o  (rxs)
  );

  // The vote completes on the cnt=9 tick using the live sample as the third.
  assign maj_d    = maj3(samp_a_q, samp_b_q, rxs);
  assign commit_d = rx_en && baud_tick && (state_q == STOP) && (cnt_q == CNT_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bi_q     <= '0;
      sh_q     <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else if (!rx_en) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bi_q    <= '0;
    end else if (baud_tick) begin
      if (cnt_q == CNT_A) samp_a_q <= rxs;
      if (cnt_q == CNT_B) samp_b_q <= rxs;
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            cnt_q   <= CNT_ONE;
          end
        end
        START: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_C && maj_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_END) begin
            state_q <= DATA;
            bi_q    <= '0;
          end
        end
        DATA: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_C) sh_q <= {maj_d, sh_q[7:1]};
          if (cnt_q == CNT_END) begin
            if (bi_q == 3'd7) state_q <= STOP;
            else              bi_q    <= bi_q + 3'd1;
          end
        end
        STOP: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_C) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_DATA;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (commit_d) begin
      if (!valid_q || rx_ack) begin
        data_q  <= sh_q;
        valid_q <= 1'b1;
        ferr_q  <= ~maj_d;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (rx_ack) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized
// frames, compared against a frame-level model of the holding register.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx_en;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ferr;
  logic       m_ovr;

  uart_rx_core #(
    .OVERSAMPLE(16),
    .RESET_DATA(8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(baud_tick),
    .rx_en    (rx_en),
    .rxd      (rxd),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'hFF;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] b, input logic stop, input logic ack);
    if (!m_valid || ack) begin
      m_data  = b;
      m_valid = 1'b1;
      m_ferr  = ~stop;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(rx_data),   32'(m_data));
    check({tag, ".valid"}, 32'(rx_valid),  32'(m_valid));
    check({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
    check({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
    check({tag, ".busy"},  32'(busy),      32'(0));
  endtask

  // One baud tick: rxd settles 3.5 clocks before the ticking edge so the
  // synchronised value is stable when the receiver samples it.
  task automatic tick(input logic v, input logic ack);
    rxd = v;
    repeat (3) @(negedge clk);
    baud_tick = 1'b1;
    rx_ack    = ack;
    @(negedge clk);
    baud_tick = 1'b0;
    rx_ack    = 1'b0;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Line level at tick idx of a frame; a glitch inverts one tick of a data bit.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int idx,
                                     input logic [7:0] gmask, input int gcnt);
    int  slot = idx / 16;
    int  j    = idx % 16;
    logic v;
    if (slot == 0) v = 1'b0;
    else if (slot <= 8) begin
      v = b[slot-1];
      if (gmask[slot-1] && j == gcnt) v = ~v;
    end else v = stop;
    return v;
  endfunction

  task automatic drive(input logic [7:0] b, input logic stop, input logic [7:0] gmask,
                       input int gcnt, input int n, input int ack_at);
    for (int i = 0; i < n; i++) tick(frame_bit(b, stop, i, gmask, gcnt), i == ack_at);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic [7:0] gmask,
                      input int gcnt, input logic ack_commit);
    drive(b, stop, gmask, gcnt, 154, ack_commit ? 153 : -1);
    model_commit(b, stop, ack_commit);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    rxd       = 1'b1;
    rx_en     = 1'b1;
    baud_tick = 1'b0;
    rx_ack    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    idle_ticks(2);

    send(8'hA5, 1'b1, 8'h00, 8, 1'b0);
    check_all("basic");
    ack_pulse();
    check_all("basic_ack");

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check("glitch.busy_start", 32'(busy), 32'(1));
    idle_ticks(7);
    check_all("glitch");

    send(8'h3C, 1'b1, 8'b0010_0100, 8, 1'b0);
    check_all("noise");
    ack_pulse();
    send(8'h55, 1'b0, 8'h00, 8, 1'b0);
    check_all("framing");
    ack_pulse();
    idle_ticks(2);

    send(8'h11, 1'b1, 8'h00, 8, 1'b0);
    idle_ticks(2);
    send(8'h22, 1'b1, 8'h00, 8, 1'b0);
    check_all("overrun");
    ack_pulse();
    check_all("overrun_ack");

    send(8'h66, 1'b1, 8'h00, 8, 1'b0);
    idle_ticks(2);
    send(8'h77, 1'b1, 8'h00, 8, 1'b1);
    check_all("ack_commit");
    ack_pulse();

    drive(8'h99, 1'b1, 8'h00, 8, 84, -1);
    check("en_abort.busy_before", 32'(busy), 32'(1));
    rx_en = 1'b0;
    @(negedge clk);
    check("en_abort.busy_after", 32'(busy), 32'(0));
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    idle_ticks(2);
    check_all("en_abort");

    for (int f = 0; f < 24; f++) begin
      logic [7:0] b;
      logic       stop;
      logic [7:0] gm;
      int         gc;
      logic       ac;
      b    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      gm   = 8'($urandom);
      gc   = 7 + $urandom_range(2);
      ac   = ($urandom_range(7) == 0);
      if ($urandom_range(1) == 1) ack_pulse();
      send(b, stop, gm, gc, ac);
      check_all($sformatf("rand%0d", f));
      idle_ticks(1 + $urandom_range(2));
    end

    drive(8'h5A, 1'b1, 8'h00, 8, 60, -1);
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("reset_mid");
    reset = 1'b0;
    idle_ticks(2);
    send(8'h81, 1'b1, 8'h00, 8, 1'b0);
    check_all("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Standalone 16x-oversampled UART receiver that feeds the memory-mapped peripheral's receive-data register (0x4000001C) and its RX-ready status bit. It takes the serial `rxd` pin and a 16x baud tick from the baud-rate generator. It delivers one validated byte at a time through a holding register with a valid/ack handshake, and reports framing and overrun errors.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit period; the counter is 4 bits wide.
- `RESET_DATA`, 8'hFF: reset and idle value of `rx_data`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  one-`clk` pulse at 16x the baud rate, synchronous to `clk`.
- `rx_en`  in  1  receiver enable (peripheral UART_CON[1]).
- `rxd`  in  1  serial input, asynchronous, idle high.
- `rx_ack`  in  1  one-cycle pulse when the CPU reads 0x4000001C.
- `rx_data`  out  8  held received byte.
- `rx_valid`  out  1  `rx_data` is new and unread (drives UART_CON[3]).
- `frame_err`  out  1  stop bit of the byte in `rx_data` sampled low.
- `overrun`  out  1  sticky: a byte was dropped because `rx_valid` was still set.
- `busy`  out  1  the state machine is not in IDLE.

## Operation
- **Input synchronisation.** `rxd` passes through 2 flip-flops, both reset to 1. All logic below uses the synchronised value `rxs`.
- **States:** IDLE, START, DATA, STOP.
- **Tick-gated logic.** Tick counter `cnt` (0..15), bit index `bi` (0..7) and shift register `sh` change only on clocks where `baud_tick`=1.
- **Mid-bit sampling.** Within every bit period, `rxs` is sampled at `cnt`=7, 8 and 9. The bit value is the 2-of-3 majority, decided at `cnt`=9.
- **IDLE.** On a tick with `rxs`=0 and `rx_en`=1: go to START with `cnt`=1. That tick counts as sample 0.
- **START.**
  - At `cnt`=9, if the majority is 1: false start, return to IDLE.
  - Otherwise, at `cnt`=15: go to DATA with `cnt`=0 and `bi`=0.
- **DATA.**
  - At `cnt`=9, shift the majority value into `sh`, LSB first.
  - At `cnt`=15, if `bi`=7 go to STOP; else increment `bi`.
- **STOP.** At `cnt`=9, commit the byte and go straight to IDLE. The remaining half bit is skipped so back-to-back frames are not lost.
- **Commit when `rx_valid`=0, or `rx_ack`=1 in the same cycle:**
  - `rx_data`<=`sh`;
  - `rx_valid`<=1;
  - `frame_err`<=~majority.
- **Commit when `rx_valid`=1 and `rx_ack`=0:**
  - the byte is dropped;
  - `overrun`<=1;
  - `rx_data` and `frame_err` are unchanged.
- **`rx_ack` without a commit:** `rx_valid`<=0 and `overrun`<=0. `rx_data` and `frame_err` hold.
- **`rx_en` deasserted in any state:** the FSM returns to IDLE on the next `clk` and the partial byte is discarded. The holding register and flags are kept.
- **`busy`** = (state != IDLE).

## Timing
- **Reset values:** state IDLE, `cnt`=0, `bi`=0, `sh`=0, `rx_data`=`RESET_DATA`, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. Both synchroniser flops are 1.
- **Reset mid-frame** aborts immediately. No partial byte is ever committed.
- **Input latency:** 2 `clk` from an `rxd` edge to `rxs`.
- **Commit latency:** `rx_valid`, `rx_data` and `frame_err` update on the same `clk` edge that samples the STOP `cnt`=9 tick. They are visible on the following cycle.
- **Frame length:** one frame from start edge to commit is 9×16+10 = 154 ticks.
- **Read handshake:** `rx_ack` has effect on every `clk` and is not tick-gated. The bus read sees the data combinationally during the ack cycle.
- **`baud_tick` held high** across consecutive clocks counts as one tick per clock; the design does not detect this.

## Structure
- **Package `uart_pkg`:**
  - enum `uart_rx_state_t` {IDLE, START, DATA, STOP};
  - localparams `OVERSAMPLE`=16, `SAMPLE_A`=7, `SAMPLE_B`=8, `SAMPLE_C`=9, `CNT_LAST`=15.
  - A future `uart_tx_core` shares this package.
- **Sub-module `uart_rx_sync`:** 2-FF synchroniser with a parameterised reset value of 1. Everything else stays in one always block for the FSM plus one for the holding register.

## Test plan
- **Basic receive.** `baud_tick` every 4 `clk`, send 0xA5 (start, 10100101 LSB-first, stop 1). Expect `rx_data`=0xA5, `rx_valid`=1 and `frame_err`=0 after 154 ticks.
- **Glitch rejection.** A 3-tick low pulse on idle `rxd` goes to START then back to IDLE at `cnt`=9. Expect no commit and `busy` low again.
- **Noise and framing.** Send 0x3C with 1-tick glitches at `cnt`=8 of bits 2 and 5. Expect `rx_data`=0x3C. Then send 0x55 with stop=0: expect `rx_data`=0x55 and `frame_err`=1.
- **Overrun.** Send 0x11 and 0x22 with no ack. Expect `rx_data`=0x11, `overrun`=1, `rx_valid`=1. Then pulse `rx_ack`: expect `rx_valid`=0 and `overrun`=0.
- **Ack and commit in the same cycle.** Pulse `rx_ack` on the commit cycle of 0x77 while 0x66 is pending. Expect `rx_data`=0x77, `rx_valid`=1, `overrun`=0.
- **Abort paths.**
  - Drop `rx_en` during DATA bit 4: IDLE on the next cycle, `rx_data` unchanged.
  - Assert `reset` mid-frame: all outputs return to their reset values, and a following 0x81 is received correctly.
